// File: rtl/imul_int_mul_step_seq.sv
// Iterative shift-and-add multiplier: a chain of nstages step units is reused every cycle
// until all 32 multiplier bits are consumed (or b runs out of set bits when early_exit=1).
module imul_int_mul_step_seq #(
  parameter int unsigned nstages    = 1,
  parameter bit          early_exit = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_val,
  output logic        req_rdy,
  input  logic [63:0] req_msg,
  output logic        resp_val,
  input  logic        resp_rdy,
  output logic [31:0] resp_msg
);

  localparam int unsigned NumCycles = 32 / nstages;
  localparam int unsigned CntW      = $clog2(NumCycles) + 1;

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e            state_q, state_d;
  logic [31:0]       a_q, a_d, b_q, b_d, result_q, result_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [31:0]       a_chain, b_chain, r_chain;
  logic              last_cycle;

  // nstages shift-and-add steps applied back to back within one cycle
  always_comb begin
    a_chain = a_q;
    b_chain = b_q;
    r_chain = result_q;
    for (int k = 0; k < int'(nstages); k++) begin
      if (b_chain[0]) begin
        r_chain = r_chain + a_chain;
      end
      a_chain = a_chain << 1;
      b_chain = b_chain >> 1;
    end
  end

  assign last_cycle = (cnt_q == CntW'(NumCycles - 1)) || (early_exit && (b_chain == '0));

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    cnt_d    = cnt_q;
    req_rdy  = 1'b0;
    resp_val = 1'b0;
    unique case (state_q)
      StIdle: begin
        req_rdy = 1'b1;
        if (req_val) begin
          a_d      = req_msg[63:32];
          b_d      = req_msg[31:0];
          result_d = '0;
          cnt_d    = '0;
          state_d  = StCalc;
        end
      end
      StCalc: begin
        a_d      = a_chain;
        b_d      = b_chain;
        result_d = r_chain;
        cnt_d    = cnt_q + CntW'(1);
        if (last_cycle) begin
          state_d = StDone;
        end
      end
      StDone: begin
        resp_val = 1'b1;
        if (resp_rdy) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      cnt_q    <= cnt_d;
    end
  end

  assign resp_msg = result_q;

endmodule

// File: tb/tb_imul_int_mul_step_seq.sv
// Bench for imul_int_mul_step_seq: five instances with different nstages/early_exit settings,
// each exercised against an arithmetic model of product and latency.
module tb_imul_int_mul_step_seq;

  localparam int NumDut = 5;
  localparam int NS [NumDut] = '{1, 2, 8, 32, 4};
  localparam bit EE [NumDut] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

  logic        clk = 1'b0;
  logic        reset;
  logic        req_val_s  [NumDut];
  logic        req_rdy_s  [NumDut];
  logic [63:0] req_msg_s  [NumDut];
  logic        resp_val_s [NumDut];
  logic        resp_rdy_s [NumDut];
  logic [31:0] resp_msg_s [NumDut];

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  imul_int_mul_step_seq #(.nstages(1), .early_exit(1'b0)) u_dut0 (
    .clk(clk), .reset(reset), .req_val(req_val_s[0]), .req_rdy(req_rdy_s[0]),
    .req_msg(req_msg_s[0]), .resp_val(resp_val_s[0]), .resp_rdy(resp_rdy_s[0]),
    .resp_msg(resp_msg_s[0]));
  imul_int_mul_step_seq #(.nstages(2), .early_exit(1'b0)) u_dut1 (
    .clk(clk), .reset(reset), .req_val(req_val_s[1]), .req_rdy(req_rdy_s[1]),
    .req_msg(req_msg_s[1]), .resp_val(resp_val_s[1]), .resp_rdy(resp_rdy_s[1]),
    .resp_msg(resp_msg_s[1]));
  imul_int_mul_step_seq #(.nstages(8), .early_exit(1'b0)) u_dut2 (
    .clk(clk), .reset(reset), .req_val(req_val_s[2]), .req_rdy(req_rdy_s[2]),
    .req_msg(req_msg_s[2]), .resp_val(resp_val_s[2]), .resp_rdy(resp_rdy_s[2]),
    .resp_msg(resp_msg_s[2]));
  imul_int_mul_step_seq #(.nstages(32), .early_exit(1'b0)) u_dut3 (
    .clk(clk), .reset(reset), .req_val(req_val_s[3]), .req_rdy(req_rdy_s[3]),
    .req_msg(req_msg_s[3]), .resp_val(resp_val_s[3]), .resp_rdy(resp_rdy_s[3]),
    .resp_msg(resp_msg_s[3]));
  imul_int_mul_step_seq #(.nstages(4), .early_exit(1'b1)) u_dut4 (
    .clk(clk), .reset(reset), .req_val(req_val_s[4]), .req_rdy(req_rdy_s[4]),
    .req_msg(req_msg_s[4]), .resp_val(resp_val_s[4]), .resp_rdy(resp_rdy_s[4]),
    .resp_msg(resp_msg_s[4]));

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Cycles from accept to resp_val, derived from how many multiplier bits must be consumed.
  function automatic int exp_lat(input int i, input logic [31:0] b);
    int hb;
    int calc;
    if (!EE[i]) return 1 + 32 / NS[i];
    hb = 0;
    for (int k = 0; k < 32; k++) if (b[k]) hb = k + 1;
    calc = (hb + NS[i] - 1) / NS[i];
    if (calc < 1) calc = 1;
    return 1 + calc;
  endfunction

  task automatic do_op(input int i, input logic [31:0] a, input logic [31:0] b,
                       input int pre, input int stall, input bit hold);
    logic [31:0] exp;
    int          n;
    int          guard;
    bit          rdy_bad;
    bit          stable_bad;
    exp = a * b;
    repeat (pre) cyc();
    req_val_s[i] = 1'b1;
    req_msg_s[i] = {a, b};
    guard = 0;
    while (!req_rdy_s[i] && guard < 100) begin
      cyc();
      guard++;
    end
    chk("accept_rdy", 32'(req_rdy_s[i]), 32'd1);
    cyc();
    req_val_s[i] = 1'b0;
    n = 1;
    rdy_bad = 1'b0;
    while (!resp_val_s[i] && n < 100) begin
      if (req_rdy_s[i]) rdy_bad = 1'b1;
      cyc();
      n++;
    end
    chk($sformatf("latency[%0d]", i), 32'(n), 32'(exp_lat(i, b)));
    chk("rdy_low_calc", 32'(rdy_bad), 32'd0);
    chk($sformatf("product[%0d] %0h*%0h", i, a, b), resp_msg_s[i], exp);
    if (hold) begin
      req_val_s[i] = 1'b1;
      req_msg_s[i] = {32'd2, 32'd21};
    end
    stable_bad = 1'b0;
    repeat (stall) begin
      cyc();
      if (!resp_val_s[i] || resp_msg_s[i] !== exp || req_rdy_s[i]) stable_bad = 1'b1;
    end
    if (stall > 0) chk("resp_hold", 32'(stable_bad), 32'd0);
    resp_rdy_s[i] = 1'b1;
    chk("rdy_low_done", 32'(req_rdy_s[i]), 32'd0);
    cyc();
    resp_rdy_s[i] = 1'b0;
    chk("resp_val_drop", 32'(resp_val_s[i]), 32'd0);
    chk("idle_rdy", 32'(req_rdy_s[i]), 32'd1);
  endtask

  initial begin
    bit seen;
    for (int i = 0; i < NumDut; i++) begin
      req_val_s[i]  = 1'b0;
      req_msg_s[i]  = '0;
      resp_rdy_s[i] = 1'b0;
    end
    reset = 1'b1;
    cyc();
    cyc();
    for (int i = 0; i < NumDut; i++) begin
      chk("rst_req_rdy", 32'(req_rdy_s[i]), 32'd1);
      chk("rst_resp_val", 32'(resp_val_s[i]), 32'd0);
      chk("rst_resp_msg", resp_msg_s[i], 32'd0);
    end
    reset = 1'b0;
    cyc();
    chk("post_rst_rdy", 32'(req_rdy_s[0]), 32'd1);
    chk("post_rst_msg", resp_msg_s[0], 32'd0);

    do_op(0, 32'd3, 32'd4, 0, 0, 1'b0);
    do_op(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 1'b0);
    do_op(0, 32'h8000_0000, 32'd2, 0, 0, 1'b0);
    do_op(0, 32'h0000_FFFF, 32'h0001_0001, 1, 0, 1'b0);

    do_op(4, 32'd7, 32'd5, 0, 0, 1'b0);
    do_op(4, 32'h1234_5678, 32'd0, 0, 0, 1'b0);
    do_op(4, 32'd3, 32'h8000_0000, 0, 0, 1'b0);

    // Backpressure with a new request waiting; it must be taken only once back in idle.
    do_op(0, 32'd6, 32'd7, 0, 10, 1'b1);
    do_op(0, 32'd2, 32'd21, 0, 0, 1'b0);

    // Reset during the tenth compute cycle discards the in-flight product.
    req_val_s[0] = 1'b1;
    req_msg_s[0] = {32'd100, 32'd100};
    chk("abort_accept", 32'(req_rdy_s[0]), 32'd1);
    cyc();
    req_val_s[0] = 1'b0;
    repeat (9) cyc();
    reset = 1'b1;
    cyc();
    chk("abort_rst_rdy", 32'(req_rdy_s[0]), 32'd1);
    chk("abort_rst_val", 32'(resp_val_s[0]), 32'd0);
    chk("abort_rst_msg", resp_msg_s[0], 32'd0);
    reset = 1'b0;
    cyc();
    chk("abort_post_rdy", 32'(req_rdy_s[0]), 32'd1);
    seen = 1'b0;
    repeat (40) begin
      cyc();
      if (resp_val_s[0]) seen = 1'b1;
    end
    chk("abort_no_resp", 32'(seen), 32'd0);
    do_op(0, 32'd2, 32'd3, 0, 0, 1'b0);

    for (int i = 0; i < 4; i++) begin
      for (int t = 0; t < 200; t++) begin
        do_op(i, $urandom, $urandom, $urandom_range(0, 2), $urandom_range(0, 3), 1'b0);
      end
    end
    for (int t = 0; t < 100; t++) begin
      do_op(4, $urandom, $urandom >> $urandom_range(0, 31), $urandom_range(0, 2),
            $urandom_range(0, 3), 1'b0);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/imul_int_mul_step_seq.md
# imul_int_mul_step_seq

Iterative shift-and-add integer multiplier controller with a datapath that time-multiplexes a chain of `nstages` shift-and-add step units. It accepts one 32×32 multiply request over a val/rdy interface and sequences the step chain for 32/`nstages` cycles, or fewer with early exit. It returns the low 32 bits of the product over a val/rdy response interface. It sits between the processor's multiply request queue and response path, and is the variable-area alternative to the fully pipelined N-stage multiplier.

## Interface
- `nstages`, default 1: step units chained per cycle; legal values are 1, 2, 4, 8, 16, 32.
- `early_exit`, default 0: when 1, computation ends as soon as the shifted `b` is zero.
- `clk`  input  1: clock; all state updates on the rising edge.
- `reset`  input  1: synchronous, active-high reset.
- `req_val`  input  1: request valid.
- `req_rdy`  output  1: block can accept a request.
- `req_msg`  input  64: operands; `a` = [63:32], `b` = [31:0].
- `resp_val`  output  1: result valid.
- `resp_rdy`  input  1: consumer can accept the result.
- `resp_msg`  output  32: product[31:0].

## Operation
- Registers:
  - `a_reg` [31:0], `b_reg` [31:0], `result_reg` [31:0].
  - Step counter `cnt`, of width clog2(32/`nstages`)+1.
  - 2-bit FSM `state`.
- States are IDLE, CALC and DONE.
- IDLE:
  - `req_rdy`=1, `resp_val`=0.
  - On `req_val`: load `a_reg`←`req_msg`[63:32], `b_reg`←`req_msg`[31:0], `result_reg`←0, `cnt`←0.
  - Then go to CALC.
- CALC:
  - `req_rdy`=0, `resp_val`=0.
  - Each cycle applies `nstages` chained steps combinationally. Per step:
    - If `b`[0], then `result` += `a` (modulo 2^32; carry out discarded).
    - `a` ← `a`<<1 (logical).
    - `b` ← `b`>>1 (logical, zero fill).
  - At the end of the chain, write the final a/b/result into the registers and set `cnt`←`cnt`+1.
  - Go to DONE when `cnt` == 32/`nstages`−1 (the last cycle).
  - If `early_exit`=1, also go to DONE when the chain's final `b` == 0.
- DONE:
  - `resp_val`=1, `req_rdy`=0.
  - `resp_msg` = `result_reg`, held stable while `resp_val`=1 and `resp_rdy`=0.
  - On `resp_rdy`, go to IDLE.
- No request is accepted in DONE, even when `resp_rdy`=1 in the same cycle. The next request is accepted one cycle later, in IDLE.
- Operands are treated as unsigned. The low 32 product bits are identical for signed operands, so no sign handling is required.
- `a_reg`, `b_reg` and `result_reg` change only on a load in IDLE or in a CALC cycle. They hold in DONE.
- Reset:
  - `state`←IDLE; `a_reg`, `b_reg`, `result_reg` and `cnt` ← 0.
  - During reset and in the cycle after, outputs are `req_rdy`=1, `resp_val`=0, `resp_msg`=0.
  - Reset asserted mid-CALC or in DONE aborts the operation; the in-flight result is never presented.
  - Reset has priority over every other transition.

## Timing
- Request handshake completes at the edge ending cycle T (`req_val`&&`req_rdy`).
- CALC occupies cycles T+1 … T+32/`nstages`.
- `resp_val`=1 from cycle T+32/`nstages`+1. Minimum latency:
  - 33 cycles for `nstages`=1.
  - 5 cycles for `nstages`=8.
  - 2 cycles for `nstages`=32.
- With `early_exit`=1, latency is 1 + ceil((index of highest set bit of `b` + 1)/`nstages`) cycles, with a minimum of 2.
  - `b`=0 gives exactly one CALC cycle.
- Minimum initiation interval is latency + 1 cycles, with `resp_rdy` tied high.
- All outputs are Moore, decoded from `state`, except `resp_msg`, which is decoded from a register. There is no combinational path from `req_val` or `resp_rdy` to any output.

## Test plan
- Basic, `nstages`=1, `early_exit`=0:
  - Stimulus: `a`=3, `b`=4.
  - Required: `resp_msg`=12 with `resp_val` rising exactly 33 cycles after the accept. `req_rdy`=0 throughout.
- Wrap and sign:
  - Stimulus: 0xFFFFFFFF×0xFFFFFFFF.
  - Required: 0x00000001.
  - Stimulus: 0x80000000×2.
  - Required: 0x00000000.
  - Stimulus: 0x0000FFFF×0x00010001.
  - Required: 0xFFFFFFFF.
- Early exit, `nstages`=4, `early_exit`=1:
  - Stimulus: `a`=7, `b`=5.
  - Required: 35, with `resp_val` 2 cycles after the accept.
  - Stimulus: `b`=0.
  - Required: 0, 2 cycles after the accept.
  - Stimulus: `b`=0x80000000.
  - Required: full 9-cycle latency.
- Backpressure:
  - Stimulus: `resp_rdy` held 0 for 10 cycles after `resp_val` rises, on 6×7.
  - Required: `resp_msg`=42 stable and `req_rdy`=0 throughout.
  - A `req_val` held high meanwhile is accepted only in the cycle after `resp_rdy`=1.
- Back-to-back random:
  - Stimulus: 200 random operand pairs for each `nstages` in {1, 2, 8, 32}, with random `req_val`/`resp_rdy` stalls.
  - Required: every response equals (a×b) mod 2^32, in order, with none dropped or duplicated.
- Reset mid-operation:
  - Stimulus: assert `reset` for 1 cycle at CALC cycle 10 of 100×100, then issue 2×3.
  - Required: no response for the aborted request; next response is 6 with the normal latency.
